// File: rtl/inyector_vc.sv
// inyector_vc: per-VC holding slots feeding the QoS block through a round-robin arbiter
module inyector_vc #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int BUF_WIDTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic src_valid,
  input  logic [$clog2(QUEUE_QUANTITY)-1:0] src_vc,
  input  logic [BUF_WIDTH:0] src_data,
  output logic src_ready,
  input  logic [QUEUE_QUANTITY-1:0] pausa,
  input  logic [QUEUE_QUANTITY-1:0] continuar,
  input  logic [QUEUE_QUANTITY-1:0] error_full,
  output logic iniciar,
  output logic push,
  output logic [$clog2(QUEUE_QUANTITY)-1:0] vc_id,
  output logic [BUF_WIDTH:0] data_word,
  output logic [QUEUE_QUANTITY-1:0] ocupado,
  output logic [QUEUE_QUANTITY-1:0] perdida,
  output logic idle
);
  localparam int VW = $clog2(QUEUE_QUANTITY);
  typedef enum logic [1:0] {INICIO, REPOSO, ENVIANDO, BLOQUEADO} estado_t;
  estado_t estado, estado_nx;
  logic [BUF_WIDTH:0] slot [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] pausado, eleg, set_oc, clr_oc;
  logic [VW-1:0] ptr, gnt, idx;
  logic gnt_vld, acc;
  assign src_ready = ~ocupado[src_vc] & (estado != INICIO);
  assign acc = src_valid & src_ready;
  assign eleg = ocupado & ~pausado & ~pausa;
  assign iniciar = estado == INICIO;
  assign push = estado == ENVIANDO;
  assign idle = (estado == REPOSO) & (ocupado == '0);
  assign set_oc = acc ? QUEUE_QUANTITY'(1) << src_vc : '0;
  assign clr_oc = gnt_vld ? QUEUE_QUANTITY'(1) << gnt : '0;
  // Search starts just after the last granted VC; offset QUEUE_QUANTITY wraps onto ptr itself
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 1; k <= QUEUE_QUANTITY; k++) begin
      idx = ptr + VW'(k);
      if (!gnt_vld && eleg[idx]) begin
        gnt_vld = 1'b1;
        gnt = idx;
      end
    end
  end
  always_comb begin
    estado_nx = (estado == INICIO) ? REPOSO :
                (|eleg) ? ENVIANDO :
                (|ocupado) ? BLOQUEADO : REPOSO;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado <= INICIO;
      ocupado <= '0;
      pausado <= '0;
      perdida <= '0;
      ptr <= VW'(QUEUE_QUANTITY - 1);
      vc_id <= '0;
      data_word <= '0;
      for (int k = 0; k < QUEUE_QUANTITY; k++) slot[k] <= '0;
    end else begin
      estado <= estado_nx;
      ocupado <= (ocupado & ~clr_oc) | set_oc;
      pausado <= pausa | (pausado & ~continuar);
      perdida <= perdida | error_full;
      if (gnt_vld) begin
        ptr <= gnt;
        vc_id <= gnt;
        data_word <= slot[gnt];
      end
      if (acc) slot[src_vc] <= src_data;
    end
  end
endmodule

// File: tb/tb_inyector_vc.sv
// tb_inyector_vc: directed checks of reset, round robin, pause/resume, loss flag and async reset
module tb_inyector_vc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic src_valid = 1'b0;
  logic [1:0] src_vc = '0;
  logic [3:0] src_data = '0;
  logic src_ready;
  logic [3:0] pausa = '0, continuar = '0, error_full = '0;
  logic iniciar, push, idle;
  logic [1:0] vc_id;
  logic [3:0] data_word, ocupado, perdida;
  int checks = 0;
  int failures = 0;

  inyector_vc dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_vc(src_vc), .src_data(src_data),
    .src_ready(src_ready), .pausa(pausa), .continuar(continuar), .error_full(error_full),
    .iniciar(iniciar), .push(push), .vc_id(vc_id), .data_word(data_word),
    .ocupado(ocupado), .perdida(perdida), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_iniciar", 32'(iniciar), 1);
    chk("rst_push", 32'(push), 0);
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_idle", 32'(idle), 0);
    chk("rst_vcid_data", {vc_id, data_word}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("inicio_iniciar", 32'(iniciar), 1);
    chk("inicio_ready", 32'(src_ready), 0);
    tick();
    chk("reposo_iniciar", 32'(iniciar), 0);
    chk("reposo_idle", 32'(idle), 1);
    chk("reposo_ready", 32'(src_ready), 1);
    // single word on VC2
    src_valid = 1; src_vc = 2; src_data = 4'hA;
    tick();
    chk("single_ocupado", 32'(ocupado), 4'b0100);
    chk("single_ready_busy", 32'(src_ready), 0);
    src_valid = 0;
    tick();
    chk("single_push", 32'(push), 1);
    chk("single_vc", 32'(vc_id), 2);
    chk("single_data", 32'(data_word), 4'hA);
    chk("single_freed", 32'(ocupado), 0);
    tick();
    chk("single_idle", 32'(idle), 1);
    chk("single_push_off", 32'(push), 0);
    chk("single_hold_data", 32'(data_word), 4'hA);
    // round robin over all four slots
    for (int i = 0; i < 4; i++) begin
      src_valid = 1; src_vc = 2'(i); src_data = 4'(i + 5);
      tick();
      if (i > 0) begin
        chk("rr_push", 32'(push), 1);
        chk("rr_vc", 32'(vc_id), 32'(i - 1));
        chk("rr_data", 32'(data_word), 32'(i + 4));
      end
    end
    src_valid = 0;
    tick();
    chk("rr_last_vc", 32'(vc_id), 3);
    chk("rr_last_data", 32'(data_word), 8);
    chk("rr_ptr", 32'(dut.ptr), 3);
    tick();
    chk("rr_idle", 32'(idle), 1);
    // pause and resume
    src_valid = 1; src_vc = 1; src_data = 4'h9;
    tick();
    src_vc = 3; src_data = 4'hC; pausa = 4'b0010;
    tick();
    src_valid = 0; pausa = 0;
    chk("pause_no_push", 32'(push), 0);
    chk("pause_bloq", 32'(dut.estado), 3);
    tick();
    chk("pause_vc3_push", 32'(push), 1);
    chk("pause_vc3_id", 32'(vc_id), 3);
    chk("pause_vc3_data", 32'(data_word), 4'hC);
    tick();
    chk("pause_held_push", 32'(push), 0);
    chk("pause_held_bloq", 32'(dut.estado), 3);
    chk("pause_held_oc", 32'(ocupado), 4'b0010);
    pausa = 4'b0010; continuar = 4'b0010;
    tick();
    pausa = 0;
    tick();
    chk("pause_both_held", 32'(push), 0);
    chk("pause_both_oc", 32'(ocupado), 4'b0010);
    continuar = 0;
    tick();
    chk("resume_push", 32'(push), 1);
    chk("resume_vc", 32'(vc_id), 1);
    chk("resume_data", 32'(data_word), 4'h9);
    continuar = 0;
    tick();
    chk("resume_idle", 32'(idle), 1);
    // loss flag
    error_full = 4'b0100;
    tick();
    error_full = 0;
    chk("loss_set", 32'(perdida), 4'b0100);
    tick();
    chk("loss_sticky", 32'(perdida), 4'b0100);
    src_valid = 1; src_vc = 2; src_data = 4'h3;
    tick();
    src_valid = 0;
    tick();
    chk("loss_push_vc", 32'(vc_id), 2);
    chk("loss_after_push", 32'(perdida), 4'b0100);
    // mid-operation reset with three paused slots and a live push
    pausa = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      src_valid = 1; src_vc = 2'(i); src_data = 4'(i);
      tick();
    end
    src_valid = 0;
    tick();
    chk("midop_push", 32'(push), 1);
    chk("midop_oc", 32'(ocupado), 4'b0111);
    #2 rst = 1'b0;
    #1;
    chk("async_oc", 32'(ocupado), 0);
    chk("async_push", 32'(push), 0);
    chk("async_iniciar", 32'(iniciar), 1);
    chk("async_perdida", 32'(perdida), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inyector_vc.md
# inyector_vc

Upstream injector for the QoS block. It accepts tagged words from a traffic source through a valid/ready handshake and parks each word in a one-entry holding slot per virtual channel. A round-robin arbiter then pushes one eligible word per cycle into the QoS block. The injector obeys the QoS block's per-VC `pausa`/`continuar` flow control, records `error_full` losses, and issues the QoS `iniciar` pulse after reset.

## Interface
- `QUEUE_QUANTITY`, 4, number of virtual channels (power of two).
- `BUF_WIDTH`, 3, data word is `BUF_WIDTH+1` bits wide.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `src_valid`  in  1  source offers a word.
- `src_vc`  in  $clog2(QUEUE_QUANTITY)  VC of offered word.
- `src_data`  in  BUF_WIDTH+1  offered word.
- `src_ready`  out  1  slot for `src_vc` is free and state is not INICIO.
- `pausa`  in  QUEUE_QUANTITY  from QoS; per-VC stop request.
- `continuar`  in  QUEUE_QUANTITY  from QoS; per-VC resume.
- `error_full`  in  QUEUE_QUANTITY  from QoS; word to VC lost.
- `iniciar`  out  1  to QoS `iniciar`.
- `push`  out  1  to QoS `enb`; write strobe.
- `vc_id`  out  $clog2(QUEUE_QUANTITY)  to QoS `vc_id`.
- `data_word`  out  BUF_WIDTH+1  to QoS `data_word`.
- `ocupado`  out  QUEUE_QUANTITY  slot occupancy.
- `perdida`  out  QUEUE_QUANTITY  sticky loss flag per VC.
- `idle`  out  1  nothing held, nothing pushed.

## Operation
- Each VC has a slot register (`ocupado[i]`, data) and a `pausado[i]` flag.
- Accept: on an edge with `src_valid & src_ready`, the slot `src_vc` is loaded and `ocupado[src_vc]`←1.
- `src_ready` = `~ocupado[src_vc]` & (estado≠INICIO). It is decoded from registered state only. There is no bypass, so a slot freed at an edge accepts again at the following edge.
- Pause update per edge:
  - `pausa[i]`=1 → `pausado[i]`←1.
  - Else `continuar[i]`=1 → `pausado[i]`←0.
  - Both high in the same cycle → pausa wins.
- Eligibility: `eleg[i]` = `ocupado[i] & ~pausado[i] & ~pausa[i]`. A pause asserted in cycle k therefore blocks a push of VC i at edge k.
- Arbiter:
  - Round-robin pointer `ptr`, reset to QUEUE_QUANTITY-1.
  - Search order is ptr+1, ptr+2, … modulo QUEUE_QUANTITY.
  - The first eligible VC g is granted, and `ptr`←g on grant only.
- Grant at an edge registers `push`←1, `vc_id`←g, `data_word`←slot g, and `ocupado[g]`←0.
- If no VC is granted, `push`←0 and `vc_id`/`data_word` hold their previous values.
- `error_full[i]`=1 at an edge → `perdida[i]`←1. Only reset clears it. There is no retransmission.
- State machine (`estado`):
  - INICIO: reset state. Next edge always → REPOSO.
  - REPOSO: next edge → ENVIANDO if any `eleg`; → BLOQUEADO if any `ocupado` but none eligible; else stays.
  - ENVIANDO: same transition rule as REPOSO.
  - BLOQUEADO: same transition rule as REPOSO.
  - `push` is 1 exactly when estado=ENVIANDO.
- `iniciar` = (estado==INICIO).
- `idle` = (estado==REPOSO) & (`ocupado`==0).

## Timing
- Reset values (held for the whole time `rst`=0, applied asynchronously):
  - estado INICIO, so `iniciar`=1.
  - `push`=0, `vc_id`=0, `data_word`=0.
  - `ocupado`=0, `pausado`=0, `perdida`=0, `ptr`=QUEUE_QUANTITY-1.
  - `idle`=0, `src_ready`=0.
- After `rst` rises, `iniciar` stays high until the first rising edge, then drops permanently.
- Latency: a word accepted at edge k is pushed at edge k+1 at the earliest, if eligible and granted.
- Per-VC throughput is 1 word / 2 cycles. Aggregate throughput is up to 1 word / cycle.
- Accept and grant on different VCs at the same edge are independent.
- A word accepted at edge k is not eligible at edge k, because the slot is still empty before that edge.
- Reset asserted mid-operation discards held words immediately; `push` drops asynchronously.
- A VC that is paused while its slot is occupied keeps its word until `continuar` arrives. Other VCs continue to flow.

## Test plan
- Reset and start: hold `rst`=0 for 3 cycles, then release. Required: `iniciar`=1 during reset and exactly 1 cycle after; `src_ready`=0 in INICIO; then `idle`=1.
- Single word: offer VC2 data 0xA at edge k. Required: `push`=1, `vc_id`=2, `data_word`=0xA after edge k+1; `ocupado[2]`=0; `idle`=1 after edge k+2.
- Round robin: fill all 4 slots in consecutive cycles, then stop offering. Required: push order 0,1,2,3, one per cycle, `ptr` wrapping back to 3.
- Pause and resume: fill VC1 and VC3; pulse `pausa[1]` in the grant cycle. Required: only VC3 is pushed and estado=BLOQUEADO while VC1 is held. Pulse `continuar[1]`; required: VC1 is pushed at the next edge. With `pausa[1]`=`continuar[1]`=1 together, VC1 stays paused.
- Loss flag: pulse `error_full[2]` for 1 cycle. Required: `perdida`=4'b0100 sticky; a later push to VC2 does not clear it; only reset clears it.
- Mid-op reset: occupy 3 slots, assert `rst` between edges. Required: `ocupado`=0, `push`=0 and `iniciar`=1 immediately, without waiting for a clock edge.
